// File: rtl/spm_arbiter_if.sv
// Bus bundle between two requesters, the shared SPM and the arbiter.
// The arbiter connects through the slave modport; the driving environment uses master.
interface spm_arbiter_if;
  logic        req0;
  logic [31:0] mp0;
  logic [31:0] mc0;
  logic        ack0;
  logic        req1;
  logic [31:0] mp1;
  logic [31:0] mc1;
  logic        ack1;
  logic        spm_start;
  logic [31:0] spm_mp;
  logic [31:0] spm_mc;
  logic [63:0] spm_p;
  logic        spm_done;
  logic [63:0] res_p;
  logic        res_vld;
  logic        res_id;
  logic        res_err;
  logic        busy;

  modport slave (
    input  req0, mp0, mc0, req1, mp1, mc1, spm_p, spm_done,
    output ack0, ack1, spm_start, spm_mp, spm_mc, res_p, res_vld, res_id, res_err, busy
  );

  modport master (
    output req0, mp0, mc0, req1, mp1, mc1, spm_p, spm_done,
    input  ack0, ack1, spm_start, spm_mp, spm_mc, res_p, res_vld, res_id, res_err, busy
  );
endinterface

// File: rtl/spm_arbiter.sv
// Round-robin arbiter sharing one serial/parallel multiplier between two requesters,
// with a WAIT-state timeout that aborts a job whose SPM never reports done.
module spm_arbiter #(
  parameter int TIMEOUT = 100
) (
  input  logic         clk,
  input  logic         rst,
  spm_arbiter_if.slave bus
);

  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              win_q, win_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              start_q, start_d;
  logic [31:0]       mp_q, mp_d;
  logic [31:0]       mc_q, mc_d;
  logic [63:0]       res_p_q, res_p_d;
  logic              res_vld_q, res_vld_d;
  logic              res_id_q, res_id_d;
  logic              res_err_q, res_err_d;
  logic              busy_q, busy_d;
  logic              pick;

  // On a tie the requester that was not served last wins.
  assign pick = (bus.req0 && bus.req1) ? ~last_q : bus.req1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    win_d     = win_q;
    mp_d      = mp_q;
    mc_d      = mc_q;
    res_p_d   = res_p_q;
    res_id_d  = res_id_q;
    res_err_d = res_err_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    start_d   = 1'b0;
    res_vld_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d = LAUNCH;
          win_d   = pick;
          mp_d    = pick ? bus.mp1 : bus.mp0;
          mc_d    = pick ? bus.mc1 : bus.mc0;
          ack0_d  = ~pick;
          ack1_d  = pick;
          start_d = 1'b1;
        end
      end
      LAUNCH: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        // cnt_q==0 is the first WAIT cycle, where done may still be left over from the previous job.
        if ((cnt_q != '0) && bus.spm_done) begin
          state_d   = RESP;
          res_p_d   = bus.spm_p;
          res_err_d = 1'b0;
          res_id_d  = win_q;
          res_vld_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = RESP;
          res_p_d   = '0;
          res_err_d = 1'b1;
          res_id_d  = win_q;
          res_vld_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        last_d  = win_q;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      win_q     <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      start_q   <= 1'b0;
      mp_q      <= '0;
      mc_q      <= '0;
      res_p_q   <= '0;
      res_vld_q <= 1'b0;
      res_id_q  <= 1'b0;
      res_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      win_q     <= win_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      start_q   <= start_d;
      mp_q      <= mp_d;
      mc_q      <= mc_d;
      res_p_q   <= res_p_d;
      res_vld_q <= res_vld_d;
      res_id_q  <= res_id_d;
      res_err_q <= res_err_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.spm_start = start_q;
  assign bus.spm_mp    = mp_q;
  assign bus.spm_mc    = mc_q;
  assign bus.res_p     = res_p_q;
  assign bus.res_vld   = res_vld_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_err   = res_err_q;
  assign bus.busy      = busy_q;

endmodule
